// File: rtl/serial_tx_ctrl_pkg.sv
// Shared constants for the 4-bit serial transmitter: word width and FSM state encoding.
package serial_tx_ctrl_pkg;

    localparam int WORD_W    = 4;
    localparam int BIT_CNT_W = 2;
    localparam int GAP_CNT_W = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_DATA  = 3'd2;
    localparam state_t ST_STOP  = 3'd3;
    localparam state_t ST_GAP   = 3'd4;

endpackage

// File: rtl/piso_shift4.sv
// 4-bit parallel-in/serial-out shift register; load wins over shift, left shift toward bit 3.
module piso_shift4
    import serial_tx_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ShiftIn,
    input  logic [WORD_W-1:0] ParallelIn,
    input  logic              load,
    input  logic              ShiftEn,
    output logic              ShiftOut,
    output logic [WORD_W-1:0] RegContent
);

    logic [WORD_W-1:0] content_d;
    logic [WORD_W-1:0] content_q;

    always_comb begin
        content_d = content_q;
        if (load) begin
            content_d = ParallelIn;
        end else if (ShiftEn) begin
            content_d = {content_q[WORD_W-2:0], ShiftIn};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            content_q <= '0;
        end else begin
            content_q <= content_d;
        end
    end

    assign ShiftOut   = content_q[WORD_W-1];
    assign RegContent = content_q;

endmodule

// File: rtl/serial_tx_ctrl.sv
// Framed serial transmitter: start bit, 4 data bits MSB first, stop bit, optional idle gap.
//
// state | meaning
// IDLE  | line high, tx_ready=1, waiting for tx_valid
// START | start bit (line low) for one cycle
// DATA  | four data bits from shift register bit 3, one per cycle
// STOP  | stop bit (line high), tx_done pulse
// GAP   | line high for GAP_CYCLES cycles before returning to IDLE
module serial_tx_ctrl
    import serial_tx_ctrl_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              ser_out,
    output logic              ser_frame,
    output logic              tx_done,
    output logic              busy
);

    localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

    state_t                 state_d,   state_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_d, bit_cnt_q;
    logic [GAP_CNT_W-1:0]   gap_cnt_d, gap_cnt_q;
    logic                   load;
    logic                   shift_en;
    logic [WORD_W-1:0]      reg_content;
    logic                   unused_shift_out;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        load      = 1'b0;
        shift_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    load    = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                bit_cnt_d = '0;
                state_d   = ST_DATA;
            end
            ST_DATA: begin
                shift_en  = 1'b1;
                bit_cnt_d = bit_cnt_q + 2'd1;
                if (bit_cnt_q == 2'd3) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (GAP_CYCLES > 0) begin
                    gap_cnt_d = GAP_LOAD;
                    state_d   = ST_GAP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                // loaded with GAP_CYCLES-1 so the terminal count lands on the last gap cycle
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    piso_shift4 u_shift (
        .clk        (clk),
        .reset_n    (reset_n),
        .ShiftIn    (1'b0),
        .ParallelIn (tx_data),
        .load       (load),
        .ShiftEn    (shift_en),
        .ShiftOut   (unused_shift_out),
        .RegContent (reg_content)
    );

    always_comb begin
        ser_out   = 1'b1;
        ser_frame = 1'b0;
        tx_done   = 1'b0;
        case (state_q)
            ST_START: ser_out = 1'b0;
            ST_DATA: begin
                ser_out   = reg_content[WORD_W-1];
                ser_frame = 1'b1;
            end
            ST_STOP: tx_done = 1'b1;
            default: ;
        endcase
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);

endmodule
